pinwheel_ram_tl_responder: RTL and testbench

PINWHEEL_RAM_TL_RESPONDER -- requirements
Module: pinwheel_ram_tl_responder

---
 rtl/pinwheel_tl_pkg.sv | 33 +++
 rtl/pinwheel_ram_tl_responder.sv | 152 +++++++++++++++
 tb/tb_pinwheel_ram_tl_responder.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pinwheel_tl_pkg.sv
// Shared definitions for the pinwheel TileLink-UL RAM responder.
// Holds the A/D channel opcode constants, the responder FSM state type and the
// byte-lane merge used for partial writes.
package pinwheel_tl_pkg;

   // A-channel opcodes
   localparam logic [2:0] OpPutFullData    = 3'd0;
   localparam logic [2:0] OpPutPartialData = 3'd1;
   localparam logic [2:0] OpGet            = 3'd4;

   // D-channel opcodes
   localparam logic [2:0] OpAccessAck     = 3'd0;
   localparam logic [2:0] OpAccessAckData = 3'd1;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StMerge,
      StResp
   } tl_state_e;

   // Replace the bytes of old_word selected by mask with those of new_word.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  mask);
      logic [31:0] lanes;
      for (int i = 0; i < 4; i++) begin
         lanes[8*i +: 8] = {8{mask[i]}};
      end
      return (old_word & ~lanes) | (new_word & lanes);
   endfunction

endpackage

// File: rtl/pinwheel_ram_tl_responder.sv
// TileLink-UL responder in front of an external synchronous block RAM.
// One request outstanding at a time: Get reads a word, PutFullData writes a
// word, PutPartialData does a read-merge-write (or just a write for a full
// mask, or nothing for an empty mask). Out-of-range addresses and unknown
// opcodes are answered with d_error and never touch the RAM.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   a_valid/a_ready       request handshake; a_opcode, a_address, a_mask, a_data
//   d_valid/d_ready       response handshake; d_opcode, d_data, d_error
//   ram_raddr/ram_rdata   RAM read port (rdata valid one cycle after raddr)
//   ram_waddr/ram_wdata/ram_wren  RAM write port
module pinwheel_ram_tl_responder
   import pinwheel_tl_pkg::*;
#(
   parameter int unsigned  size_bytes = 512,
   parameter logic [31:0]  base_addr  = 32'h0000_0000,
   localparam int unsigned addr_bits  = $clog2(size_bytes / 4)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [2:0]           a_opcode,
   input  logic [31:0]          a_address,
   input  logic [3:0]           a_mask,
   input  logic [31:0]          a_data,
   output logic                 d_valid,
   input  logic                 d_ready,
   output logic [2:0]           d_opcode,
   output logic [31:0]          d_data,
   output logic                 d_error,
   output logic [addr_bits-1:0] ram_raddr,
   output logic [addr_bits-1:0] ram_waddr,
   input  logic [31:0]          ram_rdata,
   output logic [31:0]          ram_wdata,
   output logic                 ram_wren
);

   localparam int unsigned byte_bits = $clog2(size_bytes);

   tl_state_e state_q, state_d;

   logic [2:0]           op_q;
   logic [addr_bits-1:0] addr_q;
   logic [3:0]           mask_q;
   logic [31:0]          data_q;
   logic                 err_q;
   logic [31:0]          rdata_q;

   logic                 in_range;
   logic                 op_ok;
   logic                 req_err;
   logic                 a_fire;
   logic                 is_resp;
   logic [addr_bits-1:0] req_word;
   logic [3:0]           req_mask;

   // Byte offset within the word is irrelevant for word accesses.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^a_address[1:0];

   // base_addr is aligned to size_bytes, so range check is an upper-bit compare.
   assign in_range = (a_address[31:byte_bits] == base_addr[31:byte_bits]);
   assign op_ok    = (a_opcode == OpPutFullData) || (a_opcode == OpPutPartialData) ||
                     (a_opcode == OpGet);
   assign req_err  = !in_range || !op_ok;
   assign req_word = a_address[byte_bits-1:2];
   assign a_fire   = a_valid && (state_q == StIdle);
   assign is_resp  = (state_q == StResp);

   // A full write is just a merge with every lane enabled.
   assign req_mask = (a_opcode == OpPutFullData) ? 4'hF : a_mask;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (a_valid) begin
               if (req_err) begin
                  state_d = StResp;
               end else if (a_opcode == OpGet) begin
                  state_d = StRead;
               end else if (req_mask == 4'hF) begin
                  state_d = StMerge;
               end else if (req_mask == 4'h0) begin
                  state_d = StResp;
               end else begin
                  state_d = StRead;
               end
            end
         end
         StRead:  state_d = (op_q == OpGet) ? StResp : StMerge;
         StMerge: state_d = StResp;
         StResp: begin
            if (d_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         op_q    <= '0;
         addr_q  <= '0;
         mask_q  <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (a_fire) begin
            op_q   <= a_opcode;
            addr_q <= req_word;
            mask_q <= req_mask;
            data_q <= a_data;
            err_q  <= req_err;
         end
         if (state_q == StRead) begin
            rdata_q <= ram_rdata;
         end
      end
   end

   // The read address is presented in the accept cycle so the RAM data is
   // already valid during READ; it is then held from the latched address.
   always_comb begin
      ram_raddr = addr_q;
      if (state_q == StIdle) begin
         ram_raddr = '0;
         if (a_valid && !req_err && (a_opcode != OpPutFullData)) begin
            ram_raddr = req_word;
         end
      end
   end

   // Write strobe is decoded from state so an asynchronous reset during MERGE
   // removes it before the RAM can sample it.
   assign ram_wren  = (state_q == StMerge);
   assign ram_waddr = addr_q;
   assign ram_wdata = ram_wren ? byte_merge(rdata_q, data_q, mask_q) : 32'h0;

   assign a_ready  = (state_q == StIdle);
   assign d_valid  = is_resp;
   assign d_opcode = (is_resp && (op_q == OpGet)) ? OpAccessAckData : OpAccessAck;
   assign d_error  = is_resp && err_q;
   assign d_data   = (is_resp && (op_q == OpGet) && !err_q) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_pinwheel_ram_tl_responder.sv
module tb_pinwheel_ram_tl_responder;
   import pinwheel_tl_pkg::*;

   localparam int unsigned SizeBytes = 512;
   localparam logic [31:0] Base      = 32'h0000_2000;
   localparam int unsigned Words     = SizeBytes / 4;
   localparam int unsigned AW        = $clog2(Words);

   logic          clk;
   logic          rst_n;
   logic          a_valid;
   logic          a_ready;
   logic [2:0]    a_opcode;
   logic [31:0]   a_address;
   logic [3:0]    a_mask;
   logic [31:0]   a_data;
   logic          d_valid;
   logic          d_ready;
   logic [2:0]    d_opcode;
   logic [31:0]   d_data;
   logic          d_error;
   logic [AW-1:0] ram_raddr;
   logic [AW-1:0] ram_waddr;
   logic [31:0]   ram_rdata;
   logic [31:0]   ram_wdata;
   logic          ram_wren;

   pinwheel_ram_tl_responder #(
      .size_bytes (SizeBytes),
      .base_addr  (Base)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_opcode  (a_opcode),
      .a_address (a_address),
      .a_mask    (a_mask),
      .a_data    (a_data),
      .d_valid   (d_valid),
      .d_ready   (d_ready),
      .d_opcode  (d_opcode),
      .d_data    (d_data),
      .d_error   (d_error),
      .ram_raddr (ram_raddr),
      .ram_waddr (ram_waddr),
      .ram_rdata (ram_rdata),
      .ram_wdata (ram_wdata),
      .ram_wren  (ram_wren)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External block RAM; poke port lets the bench preload contents.
   logic [31:0]   mem [Words];
   int            wren_cnt = 0;
   logic          poke_en = 1'b0;
   logic [AW-1:0] poke_addr = '0;
   logic [31:0]   poke_data = '0;

   always @(posedge clk) begin
      ram_rdata <= mem[ram_raddr];
      if (poke_en) begin
         mem[poke_addr] <= poke_data;
      end else if (ram_wren) begin
         mem[ram_waddr] <= ram_wdata;
         wren_cnt <= wren_cnt + 1;
      end
   end

   // Reference model: plain word array updated from the protocol rules.
   logic [31:0] model [Words];

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [3:0]  mask;
      logic [31:0] data;
      logic [2:0]  e_opc;
      logic [31:0] e_dat;
      logic        e_err;
      int          e_wr;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic poke(input logic [AW-1:0] addr, input logic [31:0] data);
      @(negedge clk);
      poke_en   = 1'b1;
      poke_addr = addr;
      poke_data = data;
      model[addr] = data;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   // Expected response and memory effect of one request, from the rules alone.
   task automatic ref_req(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] data, output logic [2:0] e_opc,
                          output logic [31:0] e_dat, output logic e_err, output int e_wr);
      logic          bad;
      logic [3:0]    m;
      logic [AW-1:0] w;
      bad   = !((addr >= Base) && ((addr - Base) < SizeBytes)) ||
              !((op == 3'd0) || (op == 3'd1) || (op == 3'd4));
      e_opc = (op == 3'd4) ? 3'd1 : 3'd0;
      e_err = bad;
      e_dat = 32'h0;
      e_wr  = 0;
      if (!bad) begin
         w = AW'((addr - Base) / 4);
         if (op == 3'd4) begin
            e_dat = model[w];
         end else begin
            m = (op == 3'd0) ? 4'hF : mask;
            for (int b = 0; b < 4; b++) begin
               if (m[b]) model[w][8*b +: 8] = data[8*b +: 8];
            end
            e_wr = (m != 4'h0) ? 1 : 0;
         end
      end
   endtask

   task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, output logic [2:0] r_opc,
                         output logic [31:0] r_dat, output logic r_err, output int lat,
                         output logic [AW-1:0] r_raddr, output int wr_delta);
      int wc0;
      @(negedge clk);
      chk("a_ready before request", 32'(a_ready), 32'd1);
      wc0       = wren_cnt;
      a_valid   = 1'b1;
      a_opcode  = op;
      a_address = addr;
      a_mask    = mask;
      a_data    = data;
      @(posedge clk);
      @(negedge clk);
      a_valid   = 1'b0;
      a_opcode  = 3'($urandom);
      a_address = $urandom;
      a_mask    = 4'($urandom);
      a_data    = $urandom;
      r_raddr   = ram_raddr;
      lat       = 1;
      while (!d_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("d_valid within bound", 32'(d_valid), 32'd1);
      r_opc   = d_opcode;
      r_dat   = d_data;
      r_err   = d_error;
      d_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      d_ready  = 1'b0;
      wr_delta = wren_cnt - wc0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [2:0]    r_opc;
      logic [31:0]   r_dat;
      logic          r_err;
      int            lat;
      logic [AW-1:0] r_raddr;
      int            wrd;
      logic [2:0]    e_opc;
      logic [31:0]   e_dat;
      logic          e_err;
      int            e_wr;
      logic [31:0]   old;
      logic [31:0]   hold_dat;
      logic [2:0]    hold_opc;
      int            wc;
      int            bad_ops[5];

      bad_ops   = '{2, 3, 5, 6, 7};
      rst_n     = 1'b0;
      a_valid   = 1'b0;
      a_opcode  = 3'd0;
      a_address = 32'h0;
      a_mask    = 4'h0;
      a_data    = 32'h0;
      d_ready   = 1'b0;
      #1;
      chk("reset a_ready", 32'(a_ready), 32'd1);
      chk("reset d_valid", 32'(d_valid), 32'd0);
      chk("reset d_error", 32'(d_error), 32'd0);
      chk("reset d_opcode", 32'(d_opcode), 32'd0);
      chk("reset d_data", d_data, 32'd0);
      chk("reset ram_wren", 32'(ram_wren), 32'd0);
      chk("reset ram_raddr", 32'(ram_raddr), 32'd0);
      chk("reset ram_waddr", 32'(ram_waddr), 32'd0);
      chk("reset ram_wdata", ram_wdata, 32'd0);

      for (int i = 0; i < int'(Words); i++) poke(AW'(i), $urandom);
      poke(AW'(2), 32'hDEAD_BEEF);
      poke(AW'(5), 32'hAABB_CCDD);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, expectations written out by hand.
      tbl.push_back(vec_t'{OpGet, Base + 8, 4'h0, 32'h0, 3'd1, 32'hDEAD_BEEF, 1'b0, 0});
      tbl.push_back(vec_t'{OpPutPartialData, Base + 20, 4'b0101, 32'h1122_3344,
                           3'd0, 32'h0, 1'b0, 1});
      tbl.push_back(vec_t'{OpGet, Base + 20, 4'hF, 32'h0, 3'd1, 32'hAA22_CC44, 1'b0, 0});
      tbl.push_back(vec_t'{OpGet, Base + SizeBytes, 4'h0, 32'h0, 3'd1, 32'h0, 1'b1, 0});
      tbl.push_back(vec_t'{3'd3, Base, 4'hF, 32'h5555_5555, 3'd0, 32'h0, 1'b1, 0});
      tbl.push_back(vec_t'{OpPutFullData, Base + 12, 4'h0, 32'h1234_5678, 3'd0, 32'h0, 1'b0, 1});
      tbl.push_back(vec_t'{OpGet, Base + 13, 4'h0, 32'h0, 3'd1, 32'h1234_5678, 1'b0, 0});
      tbl.push_back(vec_t'{OpPutPartialData, Base + 12, 4'h0, 32'hFFFF_FFFF,
                           3'd0, 32'h0, 1'b0, 0});
      tbl.push_back(vec_t'{OpGet, Base + 12, 4'h0, 32'h0, 3'd1, 32'h1234_5678, 1'b0, 0});
      tbl.push_back(vec_t'{OpPutPartialData, Base + 16, 4'hF, 32'hCAFE_F00D,
                           3'd0, 32'h0, 1'b0, 1});
      tbl.push_back(vec_t'{OpGet, Base + 16, 4'h0, 32'h0, 3'd1, 32'hCAFE_F00D, 1'b0, 0});
      tbl.push_back(vec_t'{OpGet, Base - 4, 4'h0, 32'h0, 3'd1, 32'h0, 1'b1, 0});
      tbl.push_back(vec_t'{OpPutPartialData, Base + 8, 4'b1000, 32'h5500_0000,
                           3'd0, 32'h0, 1'b0, 1});
      tbl.push_back(vec_t'{OpGet, Base + 8, 4'h0, 32'h0, 3'd1, 32'h55AD_BEEF, 1'b0, 0});
      tbl.push_back(vec_t'{OpPutFullData, Base + 508, 4'h3, 32'h0BAD_C0DE, 3'd0, 32'h0, 1'b0, 1});
      tbl.push_back(vec_t'{OpGet, Base + 508, 4'h0, 32'h0, 3'd1, 32'h0BAD_C0DE, 1'b0, 0});
      tbl.push_back(vec_t'{3'd5, Base + 4, 4'hF, 32'h0, 3'd0, 32'h0, 1'b1, 0});

      foreach (tbl[i]) begin
         ref_req(tbl[i].op, tbl[i].addr, tbl[i].mask, tbl[i].data, e_opc, e_dat, e_err, e_wr);
         do_req(tbl[i].op, tbl[i].addr, tbl[i].mask, tbl[i].data,
                r_opc, r_dat, r_err, lat, r_raddr, wrd);
         chk($sformatf("vec%0d d_opcode", i), 32'(r_opc), 32'(tbl[i].e_opc));
         chk($sformatf("vec%0d d_data", i), r_dat, tbl[i].e_dat);
         chk($sformatf("vec%0d d_error", i), 32'(r_err), 32'(tbl[i].e_err));
         chk($sformatf("vec%0d wren pulses", i), 32'(wrd), 32'(tbl[i].e_wr));
         if (tbl[i].e_err) begin
            chk($sformatf("vec%0d error latency", i), 32'(lat), 32'd1);
         end else if (tbl[i].op == OpGet) begin
            chk($sformatf("vec%0d get latency", i), 32'(lat), 32'd2);
            chk($sformatf("vec%0d ram_raddr", i), 32'(r_raddr),
                (tbl[i].addr - Base) >> 2);
         end
      end
      chk("word 5 after partial", mem[5], 32'hAA22_CC44);

      // Response stall: d_* held, no accept while a second request waits.
      wc = wren_cnt;
      @(negedge clk);
      a_valid   = 1'b1;
      a_opcode  = OpGet;
      a_address = Base + 8;
      @(posedge clk);
      @(negedge clk);
      a_address = Base + 20;
      for (int k = 0; k < 5 && !d_valid; k++) @(negedge clk);
      chk("stall d_valid", 32'(d_valid), 32'd1);
      hold_dat = d_data;
      hold_opc = d_opcode;
      chk("stall first d_data", hold_dat, model[2]);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall d_valid held", 32'(d_valid), 32'd1);
         chk("stall d_data held", d_data, hold_dat);
         chk("stall d_opcode held", 32'(d_opcode), 32'(hold_opc));
         chk("stall d_error held", 32'(d_error), 32'd0);
         chk("stall a_ready low", 32'(a_ready), 32'd0);
      end
      d_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      d_ready = 1'b0;
      chk("idle after handshake", 32'(a_ready), 32'd1);
      chk("no d_valid after handshake", 32'(d_valid), 32'd0);
      a_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("no second response", 32'(d_valid), 32'd0);
      chk("no write during stall", 32'(wren_cnt), 32'(wc));

      // Reset in the MERGE cycle aborts the write.
      old = model[5];
      @(negedge clk);
      a_valid   = 1'b1;
      a_opcode  = OpPutPartialData;
      a_address = Base + 20;
      a_mask    = 4'b0011;
      a_data    = 32'h0;
      @(posedge clk);
      @(negedge clk);
      a_valid = 1'b0;
      @(negedge clk);
      chk("merge wren asserted", 32'(ram_wren), 32'd1);
      wc    = wren_cnt;
      rst_n = 1'b0;
      #1;
      chk("mid reset a_ready", 32'(a_ready), 32'd1);
      chk("mid reset d_valid", 32'(d_valid), 32'd0);
      chk("mid reset d_error", 32'(d_error), 32'd0);
      chk("mid reset d_opcode", 32'(d_opcode), 32'd0);
      chk("mid reset d_data", d_data, 32'd0);
      chk("mid reset ram_wren", 32'(ram_wren), 32'd0);
      chk("mid reset ram_raddr", 32'(ram_raddr), 32'd0);
      chk("mid reset ram_waddr", 32'(ram_waddr), 32'd0);
      chk("mid reset ram_wdata", ram_wdata, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("no response after reset", 32'(d_valid), 32'd0);
      end
      chk("aborted write count", 32'(wren_cnt), 32'(wc));
      chk("aborted write ram word", mem[5], old);
      do_req(OpGet, Base + 20, 4'h0, 32'h0, r_opc, r_dat, r_err, lat, r_raddr, wrd);
      chk("get after abort", r_dat, old);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 300; n++) begin
         logic [2:0]  op;
         logic [31:0] addr;
         logic [3:0]  mask;
         logic [31:0] data;
         int unsigned sel;
         sel  = $urandom_range(0, 9);
         addr = Base + $urandom_range(0, SizeBytes - 1);
         mask = 4'($urandom);
         data = $urandom;
         if (sel < 3) op = OpGet;
         else if (sel < 5) op = OpPutFullData;
         else if (sel < 8) op = OpPutPartialData;
         else if (sel == 8) op = 3'(bad_ops[$urandom_range(0, 4)]);
         else begin
            op   = OpGet;
            addr = $urandom;
         end
         ref_req(op, addr, mask, data, e_opc, e_dat, e_err, e_wr);
         do_req(op, addr, mask, data, r_opc, r_dat, r_err, lat, r_raddr, wrd);
         chk($sformatf("rand%0d d_opcode", n), 32'(r_opc), 32'(e_opc));
         chk($sformatf("rand%0d d_data", n), r_dat, e_dat);
         chk($sformatf("rand%0d d_error", n), 32'(r_err), 32'(e_err));
         chk($sformatf("rand%0d wren pulses", n), 32'(wrd), 32'(e_wr));
         if (e_err) chk($sformatf("rand%0d error latency", n), 32'(lat), 32'd1);
         else if (op == OpGet) chk($sformatf("rand%0d get latency", n), 32'(lat), 32'd2);
      end

      for (int i = 0; i < int'(Words); i++) begin
         chk($sformatf("final ram word %0d", i), mem[i], model[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
